// File: rtl/wb_arb_pkg.sv
// Shared types for the two-master Wishbone arbiter.
// Owner state encoding and Wishbone cycle-type codes.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Per-transfer watchdog: counts strobed cycles without a response
// and pulses o_timeout for one cycle when the wait reaches TIMEOUT.
// Ports: wb_clk, wb_rst_n, i_busy (owner valid), i_stb (owner cyc&stb),
//        i_rsp (any slave response), o_timeout (single-cycle pulse).
module wb_arb_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic wb_clk,
  input  logic wb_rst_n,
  input  logic i_busy,
  input  logic i_stb,
  input  logic i_rsp,
  output logic o_timeout
);

  localparam int            LIM   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] W_LIM = CW'(LIM);
  localparam logic          EN    = (TIMEOUT != 0);

  logic [CW-1:0] r_cnt;
  logic          w_armed;

  assign w_armed   = i_busy & i_stb & ~i_rsp;
  // A response in the firing cycle disarms it, so ack beats the timeout.
  assign o_timeout = EN & w_armed & (r_cnt == W_LIM);

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_cnt <= '0;
    end else if (!w_armed || o_timeout) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone B3 round-robin arbiter.
// Ports: m0_*/m1_* master sides, s_* slave side, grant_o one-hot owner.
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic              wb_clk,
  input  logic              wb_rst_n,
  input  logic [AW-1:0]     m0_adr_i,
  input  logic [DW-1:0]     m0_dat_i,
  input  logic [DW/8-1:0]   m0_sel_i,
  input  logic              m0_we_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic [2:0]        m0_cti_i,
  input  logic [1:0]        m0_bte_i,
  output logic [DW-1:0]     m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic              m0_rty_o,
  input  logic [AW-1:0]     m1_adr_i,
  input  logic [DW-1:0]     m1_dat_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  input  logic              m1_we_i,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic [2:0]        m1_cti_i,
  input  logic [1:0]        m1_bte_i,
  output logic [DW-1:0]     m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              m1_rty_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic              s_we_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic [2:0]        s_cti_o,
  output logic [1:0]        s_bte_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic              s_rty_i,
  output logic [1:0]        grant_o
);

  arb_state_e r_state;
  logic       r_last;

  logic w_own0, w_own1;
  logic w_cyc, w_stb, w_rsp, w_to;

  assign w_own0 = (r_state == OWN0);
  assign w_own1 = (r_state == OWN1);
  assign w_rsp  = s_ack_i | s_err_i | s_rty_i;

  always_comb begin
    w_cyc   = 1'b0;
    w_stb   = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    unique case (1'b1)
      w_own0: begin
        w_cyc   = m0_cyc_i;
        w_stb   = m0_stb_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        s_we_o  = m0_we_i;
        s_cti_o = m0_cti_i;
        s_bte_o = m0_bte_i;
      end
      w_own1: begin
        w_cyc   = m1_cyc_i;
        w_stb   = m1_stb_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
        s_we_o  = m1_we_i;
        s_cti_o = m1_cti_i;
        s_bte_o = m1_bte_i;
      end
      default: ;
    endcase
  end

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_wdog (
    .wb_clk    (wb_clk),
    .wb_rst_n  (wb_rst_n),
    .i_busy    (w_own0 | w_own1),
    .i_stb     (w_cyc & w_stb),
    .i_rsp     (w_rsp),
    .o_timeout (w_to)
  );

  // The forced-err cycle withdraws the strobe so the slave never
  // sees a transfer that the master has already been told failed.
  assign s_cyc_o = w_cyc & ~w_to;
  assign s_stb_o = w_stb & ~w_to;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = w_own0 & s_ack_i;
  assign m0_err_o = w_own0 & (s_err_i | w_to);
  assign m0_rty_o = w_own0 & s_rty_i;
  assign m1_ack_o = w_own1 & s_ack_i;
  assign m1_err_o = w_own1 & (s_err_i | w_to);
  assign m1_rty_o = w_own1 & s_rty_i;
  assign grant_o  = {w_own1, w_own0};

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          // On a tie the master that did not own last wins.
          if (m0_cyc_i && (!m1_cyc_i || r_last)) r_state <= OWN0;
          else if (m1_cyc_i)                    r_state <= OWN1;
        end
        OWN0: begin
          if (!m0_cyc_i) begin
            r_last  <= 1'b0;
            r_state <= m1_cyc_i ? OWN1 : IDLE;
          end
        end
        OWN1: begin
          if (!m1_cyc_i) begin
            r_last  <= 1'b1;
            r_state <= m0_cyc_i ? OWN0 : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: directed scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_wb_arbiter_2m;
  import wb_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic wb_clk = 1'b0;
  logic wb_rst_n;
  always #5 wb_clk = ~wb_clk;

  logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o;
  logic [DW-1:0] s_dat_o, s_dat_i;
  logic [3:0]    m0_sel_i, m1_sel_i, s_sel_o;
  logic          m0_we_i, m1_we_i, s_we_o;
  logic          m0_cyc_i, m1_cyc_i, s_cyc_o;
  logic          m0_stb_i, m1_stb_i, s_stb_o;
  logic [2:0]    m0_cti_i, m1_cti_i, s_cti_o;
  logic [1:0]    m0_bte_i, m1_bte_i, s_bte_o;
  logic          m0_ack_o, m0_err_o, m0_rty_o;
  logic          m1_ack_o, m1_err_o, m1_rty_o;
  logic          s_ack_i, s_err_i, s_rty_i;
  logic [1:0]    grant_o;

  wb_arbiter_2m #(
    .AW(AW), .DW(DW), .TIMEOUT(TO), .CW(8)
  ) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o)
  );

  int n_chk = 0;
  int n_pass = 0;

  // reference model: owner (-1 none), last owner, stalled-wait length
  int md_own, md_last, md_wait;

  logic [1:0]    ob_grant;
  logic          ob_scyc, ob_sstb;
  logic [2:0]    ob_rsp0, ob_rsp1;
  logic [DW-1:0] ob_dat0;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic md_reset();
    md_own  = -1;
    md_last = 1;
    md_wait = 0;
  endtask

  task automatic idle_inputs();
    {m0_adr_i, m0_dat_i, m0_sel_i, m0_we_i} = '0;
    {m0_cyc_i, m0_stb_i, m0_cti_i, m0_bte_i} = '0;
    {m1_adr_i, m1_dat_i, m1_sel_i, m1_we_i} = '0;
    {m1_cyc_i, m1_stb_i, m1_cti_i, m1_bte_i} = '0;
    {s_dat_i, s_ack_i, s_err_i, s_rty_i} = '0;
  endtask

  // Called just after a negedge with inputs set; checks, advances model.
  task automatic tick();
    logic oc, os, rsp, to;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [10:0] ectl;
    logic [1:0] eg;
    #1;
    oc = 1'b0; os = 1'b0; ea = '0; ed = '0; ectl = '0; eg = 2'b00;
    if (md_own == 0) begin
      oc = m0_cyc_i; os = m0_stb_i; ea = m0_adr_i; ed = m0_dat_i;
      ectl = {m0_we_i, m0_sel_i, m0_cti_i, m0_bte_i}; eg = 2'b01;
    end else if (md_own == 1) begin
      oc = m1_cyc_i; os = m1_stb_i; ea = m1_adr_i; ed = m1_dat_i;
      ectl = {m1_we_i, m1_sel_i, m1_cti_i, m1_bte_i}; eg = 2'b10;
    end
    rsp = s_ack_i | s_err_i | s_rty_i;
    to  = (md_own >= 0) && oc && os && !rsp && (md_wait == TO - 1);
    check("grant", grant_o, eg);
    check("s_cyc", s_cyc_o, oc & ~to);
    check("s_stb", s_stb_o, os & ~to);
    check("s_adr", s_adr_o, ea);
    check("s_dat", s_dat_o, ed);
    check("s_ctl", {s_we_o, s_sel_o, s_cti_o, s_bte_o}, ectl);
    check("m0_rsp", {m0_ack_o, m0_err_o, m0_rty_o},
          (md_own == 0) ? {s_ack_i, s_err_i | to, s_rty_i} : 3'b000);
    check("m1_rsp", {m1_ack_o, m1_err_o, m1_rty_o},
          (md_own == 1) ? {s_ack_i, s_err_i | to, s_rty_i} : 3'b000);
    check("m_dat", {m0_dat_o, m1_dat_o}, {s_dat_i, s_dat_i});
    ob_grant = grant_o; ob_scyc = s_cyc_o; ob_sstb = s_stb_o;
    ob_rsp0 = {m0_ack_o, m0_err_o, m0_rty_o};
    ob_rsp1 = {m1_ack_o, m1_err_o, m1_rty_o};
    ob_dat0 = m0_dat_o;
    if (md_own < 0 || !(oc && os) || rsp || to) md_wait = 0;
    else md_wait++;
    if (md_own < 0) begin
      if (m0_cyc_i && m1_cyc_i) md_own = (md_last == 0) ? 1 : 0;
      else if (m0_cyc_i) md_own = 0;
      else if (m1_cyc_i) md_own = 1;
    end else if (!oc) begin
      md_last = md_own;
      if (md_own == 0) md_own = m1_cyc_i ? 1 : -1;
      else             md_own = m0_cyc_i ? 0 : -1;
    end
    @(negedge wb_clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    wb_rst_n = 1'b0;
    @(negedge wb_clk);
    #1;
    check("rst_grant", grant_o, 2'b00);
    check("rst_scyc", {s_cyc_o, s_stb_o}, 2'b00);
    check("rst_rsp", {m0_ack_o, m0_err_o, m0_rty_o,
                      m1_ack_o, m1_err_o, m1_rty_o}, 6'd0);
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    md_reset();
  endtask

  initial begin
    int fire, a0, a1;
    logic sstb_at, e1, e0, quiet;
    md_reset();
    idle_inputs();
    wb_rst_n = 1'b0;
    @(negedge wb_clk);

    // single read from m0
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h100;
    tick(); check("rd_c0_scyc", ob_scyc, 1'b0);
    tick(); check("rd_c1_scyc", ob_scyc, 1'b1);
    check("rd_grant", ob_grant, 2'b01);
    s_ack_i = 1; s_dat_i = 32'hDEADBEEF;
    tick(); check("rd_ack", ob_rsp0, 3'b100);
    check("rd_dat", ob_dat0, 32'hDEADBEEF);
    idle_inputs(); tick();

    // simultaneous request, handover, next tie
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    tick(); tick(); check("tie_grant", ob_grant, 2'b01);
    m0_cyc_i = 0; m0_stb_i = 0;
    tick(); check("rel_grant", ob_grant, 2'b01);
    tick(); check("handover", ob_grant, 2'b10);
    m1_cyc_i = 0; m1_stb_i = 0;
    tick(); tick(); check("idle_grant", ob_grant, 2'b00);
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    tick(); tick(); check("tie2_grant", ob_grant, 2'b01);
    idle_inputs(); tick(); tick();

    // burst lock for m1
    do_reset();
    m1_cyc_i = 1; m1_stb_i = 1; m1_cti_i = CTI_INCR;
    tick();
    m0_cyc_i = 1; m0_stb_i = 1;
    a0 = 0; a1 = 0;
    for (int b = 0; b < 4; b++) begin
      m1_cti_i = (b == 3) ? CTI_EOB : CTI_INCR;
      m1_adr_i = 32'h200 + 32'(b * 4);
      s_ack_i = 1;
      tick();
      a0 += int'(ob_rsp0[2]);
      a1 += int'(ob_rsp1[2]);
    end
    check("burst_m1_acks", a1, 4);
    check("burst_m0_acks", a0, 0);
    m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
    tick(); check("burst_rel", ob_grant, 2'b10);
    tick(); check("burst_m0_gnt", ob_grant, 2'b01);
    idle_inputs(); tick(); tick();

    // watchdog fires 8 cycles after stb
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    tick();
    fire = 0; sstb_at = 1'b1; e1 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      e1 |= ob_rsp1[1];
      if (ob_rsp0[1] && fire == 0) begin
        fire = k; sstb_at = ob_sstb;
      end
    end
    check("wd_cycle", fire, 8);
    check("wd_sstb", sstb_at, 1'b0);
    check("wd_m1err", e1, 1'b0);
    idle_inputs(); tick(); tick(); tick();

    // ack in the firing cycle wins
    do_reset();
    m0_cyc_i = 1; m0_stb_i = 1;
    tick();
    for (int k = 1; k < 8; k++) tick();
    s_ack_i = 1;
    tick(); check("race_ack", ob_rsp0, 3'b100);
    s_ack_i = 0; e0 = 1'b0;
    for (int k = 1; k < 8; k++) begin
      tick(); e0 |= ob_rsp0[1];
    end
    check("race_noerr", e0, 1'b0);
    tick(); check("race_refire", ob_rsp0[1], 1'b1);
    idle_inputs(); tick(); tick();

    // asynchronous reset mid-burst
    do_reset();
    m1_cyc_i = 1; m1_stb_i = 1; m1_cti_i = CTI_INCR;
    tick(); tick(); check("ar_pre", ob_grant, 2'b10);
    s_ack_i = 1;
    #3 wb_rst_n = 1'b0;
    #1;
    check("ar_grant", grant_o, 2'b00);
    check("ar_scyc", s_cyc_o, 1'b0);
    check("ar_rsp", {m0_ack_o, m0_err_o, m0_rty_o,
                     m1_ack_o, m1_err_o, m1_rty_o}, 6'd0);
    @(negedge wb_clk);
    idle_inputs();
    wb_rst_n = 1'b1;
    md_reset();
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    tick(); tick(); check("ar_tie", ob_grant, 2'b01);
    idle_inputs(); tick(); tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      quiet = ((i / 200) % 3) == 2;
      if (quiet) begin
        m0_cyc_i = m0_cyc_i ? ($urandom_range(19) != 0)
                            : ($urandom_range(2) == 0);
        m1_cyc_i = m1_cyc_i ? ($urandom_range(19) != 0)
                            : ($urandom_range(2) == 0);
        m0_stb_i = m0_cyc_i;
        m1_stb_i = m1_cyc_i;
      end else begin
        m0_cyc_i = m0_cyc_i ? ($urandom_range(4) != 0)
                            : ($urandom_range(2) == 0);
        m1_cyc_i = m1_cyc_i ? ($urandom_range(4) != 0)
                            : ($urandom_range(2) == 0);
        m0_stb_i = m0_cyc_i & ($urandom_range(3) != 0);
        m1_stb_i = m1_cyc_i & ($urandom_range(3) != 0);
      end
      m0_adr_i = $urandom; m0_dat_i = $urandom;
      m1_adr_i = $urandom; m1_dat_i = $urandom;
      m0_sel_i = 4'($urandom); m1_sel_i = 4'($urandom);
      m0_we_i = 1'($urandom); m1_we_i = 1'($urandom);
      m0_cti_i = 3'($urandom); m1_cti_i = 3'($urandom);
      m0_bte_i = 2'($urandom); m1_bte_i = 2'($urandom);
      s_dat_i = $urandom;
      if (quiet) begin
        s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
      end else begin
        s_ack_i = ($urandom_range(2) == 0);
        s_err_i = ($urandom_range(15) == 0);
        s_rty_i = ($urandom_range(15) == 0);
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
- Two-master, one-slave Wishbone B3 arbiter.
- Lets the mor1kx instruction bus (m0) and data bus (m1) share a single wb_ram / slave port.
- Round-robin grant with a registered owner.
- A per-transfer watchdog terminates stalled accesses with err.
- Sits between the CPU bus masters and the slave-side interconnect.

Parameters:
- AW, 32, address width.
- DW, 32, data width; select width is DW/8.
- TIMEOUT, 255, cycles a strobed transfer may wait for ack/err/rty before the arbiter forces err; 0 disables the watchdog.
- CW, 8, watchdog counter width; TIMEOUT must be less than 2^CW.

Ports:
- wb_clk  in  1  clock; all logic rising-edge.
- wb_rst_n  in  1  asynchronous, active-low reset.
- m{0,1}_adr_i  in  AW  master address.
- m{0,1}_dat_i  in  DW  master write data.
- m{0,1}_sel_i  in  DW/8  byte selects.
- m{0,1}_we_i  in  1  write enable.
- m{0,1}_cyc_i  in  1  cycle request.
- m{0,1}_stb_i  in  1  strobe.
- m{0,1}_cti_i  in  3  cycle type.
- m{0,1}_bte_i  in  2  burst type.
- m{0,1}_dat_o  out  DW  read data (s_dat_i broadcast to both masters).
- m{0,1}_ack_o  out  1  ack, owner only.
- m{0,1}_err_o  out  1  err, owner only, or watchdog.
- m{0,1}_rty_o  out  1  rty, owner only.
- s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o  out  (AW, DW, DW/8, 1, 1, 1, 3, 2)  muxed from owner.
- s_dat_i  in  DW  slave read data.
- s_ack_i  in  1  slave ack.
- s_err_i  in  1  slave err.
- s_rty_i  in  1  slave rty.
- grant_o  out  2  one-hot owner ({m1,m0}), 2'b00 when idle; debug.

Behaviour:
- State register: IDLE, OWN0, OWN1. Reset (wb_rst_n low, async) forces IDLE.
- Round-robin pointer last_owner resets to 1, so m0 wins the first tie.
- IDLE:
  - Only m0_cyc high -> OWN0.
  - Only m1_cyc high -> OWN1.
  - Both high -> the master that is not last_owner.
  - Neither high -> stay.
  - Slave outputs are all zero in IDLE. Arbitration therefore costs exactly one cycle from cyc assertion to s_cyc_o.
- OWNn:
  - All s_* outputs are combinationally driven from mn_*.
  - s_cyc_o = mn_cyc_i, s_stb_o = mn_stb_i, gated low during a watchdog err cycle.
  - The grant is held for as long as mn_cyc_i stays high; bursts (cti 3'b010) and back-to-back single transfers are never split.
- Release from OWNn when mn_cyc_i is sampled low:
  - Other master's cyc high -> go directly to the other OWN state (no idle bubble).
  - Otherwise -> IDLE.
  - last_owner <= n either way.
- Response routing: the owner receives s_ack_i, s_err_i, s_rty_i. The non-owner's ack, err and rty are 0 at all times.
- m0_dat_o = m1_dat_o = s_dat_i.
- Watchdog counter:
  - Cleared in IDLE, on any s_ack_i/s_err_i/s_rty_i, and whenever s_stb_o is low.
  - Increments each cycle the owner has stb high with no response.
  - When count == TIMEOUT-1 and there is still no response: drive owner err_o=1 for one cycle, force s_cyc_o/s_stb_o low that cycle, clear the counter.
  - The grant is kept; the master decides whether to drop cyc.
- Simultaneous events:
  - s_ack_i in the same cycle the watchdog would fire -> ack wins, no err.
  - Owner drops cyc while the other master requests -> handover on that edge.
- Reset mid-transfer: outputs go to zero asynchronously; no response is delivered to the interrupted master.
- Reset values: all s_* outputs, all ack/err/rty outputs and grant_o are 0. dat_o follows s_dat_i.

Decomposition:
- Shared package wb_arb_pkg holds:
  - state encoding constants: IDLE=2'd0, OWN0=2'd1, OWN1=2'd2;
  - Wishbone CTI constants: CLASSIC 3'b000, INCR 3'b010, EOB 3'b111.
- One sub-module is natural: wb_arb_watchdog (counter, TIMEOUT compare, clear logic, timeout pulse output).
- Muxing and the FSM stay in the top module.

Test Plan:
- m0 single read: m0_cyc/stb at cycle 0, adr 0x100; slave acks at cycle 2 with dat 0xDEADBEEF.
  -> s_cyc_o rises at cycle 1, m0_ack_o at cycle 2, m0_dat_o=0xDEADBEEF, grant_o=2'b01.
- Simultaneous request: m0 and m1 both raise cyc out of reset.
  -> m0 is granted first; after m0 drops cyc, m1 is granted on the next edge with no IDLE cycle in between.
  -> The next tie goes to m0 again (last_owner=1).
- Burst lock: m1 runs a 4-beat INCR burst (cti 010, 010, 010, 111) while m0 requests.
  -> All 4 acks go to m1; m0_ack_o stays 0; m0 is granted only after m1_cyc drops.
- Watchdog: TIMEOUT=8, m0 strobes and the slave never responds.
  -> m0_err_o pulses exactly 8 cycles after stb with s_stb_o low that cycle; m1 sees no err.
- Ack/timeout race: slave acks exactly at cycle TIMEOUT-1.
  -> ack delivered, err stays 0, counter cleared.
- Async reset: assert wb_rst_n low mid-burst with grant_o=2'b10.
  -> grant_o=0, s_cyc_o=0 and all ack/err/rty=0 immediately, without waiting for a clock edge.
  -> After release, the first tie goes to m0.
